hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
Pipeline sequencing controller for the 5-stage CPU (IF/ID/EX/MEM/WB). It consumes the ID-stage decode outputs (write enable, memory read, destination/source registers, multiply flag) and the EX-stage branch resolution. It drives stall, hold, bubble and flush controls for the PC, IF/ID, ID/EX and EX/MEM pipeline registers. It covers load-use interlock, the multi-cycle MUL occupancy of EX, taken-BEQ squash, and a saturating stall-cycle counter.

Parameters:
REG_AW, 5, register address width
MUL_LAT, 4, EX cycles a MUL occupies (>=1); 1 = single-cycle, no busy state
CNT_W, 16, stall counter width

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  ID holds a real (non-bubble) instruction
id_rs  in  REG_AW  ID source register 1
id_rt  in  REG_AW  ID source register 2
id_uses_rt  in  1  ID instruction reads rt (R-type, SW, BEQ)
id_wen  in  1  ID instruction writes a register (decoder wen)
id_memread  in  1  ID instruction is LW (decoder MemRead)
id_is_mul  in  1  ID instruction is MUL
id_dst  in  REG_AW  ID destination register after regdst select
ex_branch_taken  in  1  BEQ in EX resolved taken this cycle
stall_f  out  1  hold PC and IF/ID
flush_d  out  1  clear IF/ID to NOP
bubble_e  out  1  load NOP into ID/EX
hold_e  out  1  hold ID/EX contents
bubble_m  out  1  load NOP into EX/MEM
mul_busy  out  1  FSM in MUL_BUSY
stall_cnt  out  CNT_W  saturating count of cycles with stall_f=1

Behaviour:
- Reset (async, rst_n=0): FSM=RUN, ex_ld_valid=0, ex_ld_dst=0, mul counter=0, stall_cnt=0. All control outputs are 0 while in reset.
- State: ex_ld_valid/ex_ld_dst track a LW in EX. Each edge with hold_e=0, they load {id_valid&id_memread&id_wen&~bubble_e, id_dst}. With hold_e=1 they keep their value.
- load_use (combinational) = id_valid & ex_ld_valid & (ex_ld_dst!=0) & ((id_rs==ex_ld_dst) | (id_uses_rt & id_rt==ex_ld_dst)).
- FSM RUN, priority order:
  1. ex_branch_taken: flush_d=1, bubble_e=1, stall_f=0. The PC takes the target and overrides load_use.
  2. load_use: stall_f=1, bubble_e=1 for exactly 1 cycle. Next cycle ex_ld_valid=0, so the stall releases.
  3. id_valid & id_is_mul & MUL_LAT>1: the MUL issues normally this cycle (no stall). The FSM goes to MUL_BUSY with counter=MUL_LAT-2.
  4. Otherwise all controls are 0.
- FSM MUL_BUSY: stall_f=1, hold_e=1, bubble_m=1, mul_busy=1. Counter decrements each cycle. When the counter is 0, go to RUN at the next edge. Total busy cycles = MUL_LAT-1, so the MUL result enters EX/MEM at issue+MUL_LAT. In this state ex_branch_taken and load_use are ignored, because EX holds the MUL. A MUL followed immediately by a MUL re-enters MUL_BUSY only after RUN re-evaluates ID.
- Reset during MUL_BUSY: immediate return to RUN with controls 0. In-flight pipeline contents are the top level's responsibility.
- Register 0 never causes a load-use stall.
- stall_cnt increments each cycle stall_f=1 and saturates at all-ones (no wrap).
- Outputs are combinational from state and inputs; no added latency.

Test Plan:
- LW r3 then ADD r4,r3,r5 (rs match) -> one cycle stall_f=1, bubble_e=1; next cycle all 0; stall_cnt=1.
- LW r0 then ADD using r0; LW r3 then ADDI with rt=r3 and id_uses_rt=0 -> no stall in either case.
- MUL with MUL_LAT=4 -> mul_busy, stall_f, hold_e, bubble_m high for exactly 3 cycles after issue; stall_cnt +3. With MUL_LAT=1 -> no busy.
- ex_branch_taken coincident with load_use -> flush_d=1, bubble_e=1, stall_f=0; following cycle no stall since ex_ld_valid=0.
- Drop rst_n to 0 during cycle 2 of MUL_BUSY -> all outputs 0 immediately, stall_cnt=0; after release, FSM in RUN.
- CNT_W=4 with 20 consecutive load-use stalls -> stall_cnt holds at 15.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use interlock, MUL occupancy, taken-branch squash and stall count; ID decode + EX branch in, PC/IF-ID/ID-EX/EX-MEM controls out
module hazard_ctrl #(
  parameter int REG_AW  = 5,
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  input  logic              id_wen,
  input  logic              id_memread,
  input  logic              id_is_mul,
  input  logic [REG_AW-1:0] id_dst,
  input  logic              ex_branch_taken,
  output logic              stall_f,
  output logic              flush_d,
  output logic              bubble_e,
  output logic              hold_e,
  output logic              bubble_m,
  output logic              mul_busy,
  output logic [CNT_W-1:0]  stall_cnt
);
  localparam logic [0:0] RUN      = 1'b0;
  localparam logic [0:0] MUL_BUSY = 1'b1;
  localparam int         MC_W     = $clog2(MUL_LAT + 1);
  localparam logic       MUL_MC   = MUL_LAT > 1;
  logic [0:0]        state;
  logic [MC_W-1:0]   mul_cnt;
  logic              ex_ld_valid;
  logic [REG_AW-1:0] ex_ld_dst;
  logic              load_use, run, busy, br, lu, mul_go;
  always_comb begin
    load_use = id_valid & ex_ld_valid & (ex_ld_dst != '0) &
               ((id_rs == ex_ld_dst) | (id_uses_rt & (id_rt == ex_ld_dst)));
    run      = rst_n & (state == RUN);
    busy     = rst_n & (state == MUL_BUSY);
    br       = run & ex_branch_taken;
    lu       = run & ~ex_branch_taken & load_use;
    mul_go   = run & ~ex_branch_taken & ~load_use & id_valid & id_is_mul & MUL_MC;
    stall_f  = lu | busy;
    flush_d  = br;
    bubble_e = br | lu;
    hold_e   = busy;
    bubble_m = busy;
    mul_busy = busy;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      mul_cnt     <= '0;
      ex_ld_valid <= 1'b0;
      ex_ld_dst   <= '0;
      stall_cnt   <= '0;
    end else begin
      if (!hold_e) begin
        ex_ld_valid <= id_valid & id_memread & id_wen & ~bubble_e;
        ex_ld_dst   <= id_dst;
      end
      if (stall_f && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
      if (mul_go) begin
        state   <= MUL_BUSY;
        mul_cnt <= MC_W'(MUL_LAT - 2);
      end else if (busy) begin
        if (mul_cnt == '0) state <= RUN;
        else mul_cnt <= mul_cnt - MC_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vectors into a scoreboard queue, checked by an independent monitor
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic id_valid = 1'b0, id_uses_rt = 1'b0, id_wen = 1'b0, id_memread = 1'b0, id_is_mul = 1'b0, ex_branch_taken = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, id_dst = '0;
  logic stall_f, flush_d, bubble_e, hold_e, bubble_m, mul_busy;
  logic [15:0] stall_cnt;
  logic s4_stall_f, s4_flush_d, s4_bubble_e, s4_hold_e, s4_bubble_m, s4_mul_busy;
  logic [3:0] s4_cnt;
  logic l1_stall_f, l1_flush_d, l1_bubble_e, l1_hold_e, l1_bubble_m, l1_mul_busy;
  logic [15:0] l1_cnt;
  int compared = 0;
  int mismatched = 0;
  typedef struct packed {
    logic [5:0]  c;
    logic [15:0] n;
    logic [3:0]  n4;
    logic [1:0]  c1;
  } exp_t;
  exp_t q[$];
  localparam logic [5:0] C0  = 6'b000000;
  localparam logic [5:0] CLU = 6'b101000;
  localparam logic [5:0] CBR = 6'b011000;
  localparam logic [5:0] CMB = 6'b100111;
  always #5 clk = ~clk;
  hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .id_wen(id_wen), .id_memread(id_memread), .id_is_mul(id_is_mul),
    .id_dst(id_dst), .ex_branch_taken(ex_branch_taken), .stall_f(stall_f), .flush_d(flush_d),
    .bubble_e(bubble_e), .hold_e(hold_e), .bubble_m(bubble_m), .mul_busy(mul_busy), .stall_cnt(stall_cnt)
  );
  hazard_ctrl #(.CNT_W(4)) dut_c4 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .id_wen(id_wen), .id_memread(id_memread), .id_is_mul(id_is_mul),
    .id_dst(id_dst), .ex_branch_taken(ex_branch_taken), .stall_f(s4_stall_f), .flush_d(s4_flush_d),
    .bubble_e(s4_bubble_e), .hold_e(s4_hold_e), .bubble_m(s4_bubble_m), .mul_busy(s4_mul_busy), .stall_cnt(s4_cnt)
  );
  hazard_ctrl #(.MUL_LAT(1)) dut_l1 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .id_wen(id_wen), .id_memread(id_memread), .id_is_mul(id_is_mul),
    .id_dst(id_dst), .ex_branch_taken(ex_branch_taken), .stall_f(l1_stall_f), .flush_d(l1_flush_d),
    .bubble_e(l1_bubble_e), .hold_e(l1_hold_e), .bubble_m(l1_bubble_m), .mul_busy(l1_mul_busy), .stall_cnt(l1_cnt)
  );
  task automatic step(input logic r, input logic v, input logic [4:0] rs, input logic [4:0] rt,
                      input logic ur, input logic wen, input logic mr, input logic mul,
                      input logic [4:0] dst, input logic br, input logic [5:0] c,
                      input logic [15:0] n, input logic [3:0] n4, input logic [1:0] c1);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = r; id_valid = v; id_rs = rs; id_rt = rt; id_uses_rt = ur; id_wen = wen;
    id_memread = mr; id_is_mul = mul; id_dst = dst; ex_branch_taken = br;
    e.c = c; e.n = n; e.n4 = n4; e.c1 = c1;
    q.push_back(e);
  endtask
  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      logic [5:0] a;
      e = q.pop_front();
      a = {stall_f, flush_d, bubble_e, hold_e, bubble_m, mul_busy};
      compared += 4;
      if (a != e.c) begin
        mismatched++;
        $display("FAIL ctrl t=%0t got=%b want=%b", $time, a, e.c);
      end
      if (stall_cnt != e.n) begin
        mismatched++;
        $display("FAIL stall_cnt t=%0t got=%0d want=%0d", $time, stall_cnt, e.n);
      end
      if (s4_cnt != e.n4) begin
        mismatched++;
        $display("FAIL stall_cnt_w4 t=%0t got=%0d want=%0d", $time, s4_cnt, e.n4);
      end
      if ({l1_stall_f, l1_mul_busy} != e.c1) begin
        mismatched++;
        $display("FAIL lat1_ctrl t=%0t got=%b want=%b", $time, {l1_stall_f, l1_mul_busy}, e.c1);
      end
    end
  end
  initial begin
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C0,  0, 0, 2'b00);
    step(1, 1, 0, 0, 0, 1, 1, 0, 3, 0, C0,  0, 0, 2'b00);
    step(1, 1, 3, 5, 1, 1, 0, 0, 4, 0, CLU, 0, 0, 2'b10);
    step(1, 1, 3, 5, 1, 1, 0, 0, 4, 0, C0,  1, 1, 2'b00);
    step(1, 1, 0, 0, 0, 1, 1, 0, 0, 0, C0,  1, 1, 2'b00);
    step(1, 1, 0, 0, 1, 1, 0, 0, 1, 0, C0,  1, 1, 2'b00);
    step(1, 1, 0, 0, 0, 1, 1, 0, 3, 0, C0,  1, 1, 2'b00);
    step(1, 1, 1, 3, 0, 1, 0, 0, 3, 0, C0,  1, 1, 2'b00);
    step(1, 1, 0, 0, 0, 1, 1, 0, 7, 0, C0,  1, 1, 2'b00);
    step(1, 1, 2, 7, 1, 0, 0, 0, 0, 0, CLU, 1, 1, 2'b10);
    step(1, 1, 2, 7, 1, 0, 0, 0, 0, 0, C0,  2, 2, 2'b00);
    step(1, 1, 1, 2, 1, 1, 0, 1, 8, 0, C0,  2, 2, 2'b00);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, CMB, 2, 2, 2'b00);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, CMB, 3, 3, 2'b00);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, CMB, 4, 4, 2'b00);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C0,  5, 5, 2'b00);
    step(1, 1, 0, 0, 0, 1, 1, 0, 3, 0, C0,  5, 5, 2'b00);
    step(1, 1, 3, 5, 1, 1, 0, 0, 4, 1, CBR, 5, 5, 2'b00);
    step(1, 1, 3, 5, 1, 1, 0, 0, 4, 0, C0,  5, 5, 2'b00);
    step(1, 1, 1, 2, 1, 1, 0, 1, 9, 0, C0,  5, 5, 2'b00);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, CMB, 5, 5, 2'b00);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C0,  0, 0, 2'b00);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C0,  0, 0, 2'b00);
    for (int i = 0; i < 20; i++) begin
      step(1, 1, 0, 0, 0, 1, 1, 0, 3, 0, C0,  16'(i), (i > 15) ? 4'd15 : 4'(i), 2'b00);
      step(1, 1, 3, 5, 1, 1, 0, 0, 4, 0, CLU, 16'(i), (i > 15) ? 4'd15 : 4'(i), 2'b10);
    end
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C0, 20, 15, 2'b00);
    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain got=%0d pending want=0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
